// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared state encoding and helpers for regfile_arbiter
package regfile_arb_pkg;

    // One-hot state encoding: each phase of an operation owns one bit.
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'b001,
        ISSUE = 3'b010,
        DONE  = 3'b100
    } state_e;

    // Width of a requester index; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_grant
//   req        : per-requester request vector
//   last_grant : index of the previous winner; search begins one above it
//   en         : when low no grant is produced
//   grant      : one-hot winner
//   grant_idx  : binary index of the winner (0 when nothing granted)
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]            req,
    input  logic [idx_width(NREQ)-1:0] last_grant,
    input  logic                       en,
    output logic [NREQ-1:0]            grant,
    output logic [idx_width(NREQ)-1:0] grant_idx
);

    localparam int IW = idx_width(NREQ);

    logic [IW-1:0] cand;
    logic          found;

    // Walk the requesters in rotated order, nearest-after-last first, and
    // take the first one asking. Visiting last_grant itself last is what
    // bounds any requester's wait to NREQ operations.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(last_grant) + 1 + k) % NREQ);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin sharing of one regfile between NREQ requesters
//   Clk, Rst          : clock, synchronous active-high reset
//   req_valid/we      : per-requester request and direction (1 = write)
//   req_addr/wdata    : flattened payloads, requester i at [i*W +: W]
//   req_ready         : one-hot accept pulse (IDLE only)
//   rsp_valid/rdata   : one-hot completion pulse and shared read data
//   rf_CS/WE/RD       : regfile controls, asserted only in ISSUE
//   rf_Addr/dataIn    : regfile address and write data
//   rf_dataOut        : regfile registered read data
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int ADR  = 8,
    parameter int DAT  = 8,
    parameter int NREQ = 2
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ-1:0]     req_we,
    input  logic [NREQ*ADR-1:0] req_addr,
    input  logic [NREQ*DAT-1:0] req_wdata,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [DAT-1:0]      rsp_rdata,
    output logic                rf_CS,
    output logic                rf_WE,
    output logic                rf_RD,
    output logic [ADR-1:0]      rf_Addr,
    output logic [DAT-1:0]      rf_dataIn,
    input  logic [DAT-1:0]      rf_dataOut
);

    localparam int IW = idx_width(NREQ);

    state_e         state_q,      state_d;
    logic [IW-1:0]  op_idx_q,     op_idx_d;
    logic           op_we_q,      op_we_d;
    logic [ADR-1:0] op_addr_q,    op_addr_d;
    logic [DAT-1:0] op_wdata_q,   op_wdata_d;
    logic [IW-1:0]  last_grant_q, last_grant_d;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_en;

    logic            sel_we;
    logic [ADR-1:0]  sel_addr;
    logic [DAT-1:0]  sel_wdata;
    logic [NREQ-1:0] op_onehot;

    // Reset gates the arbiter directly so a request pending during reset
    // is never shown ready.
    assign arb_en = (state_q == IDLE) && !Rst;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .en         (arb_en),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    // The grant is one-hot, so an OR of masked payloads selects the winner.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_we    = sel_we    | req_we[i];
                sel_addr  = sel_addr  | req_addr[i*ADR +: ADR];
                sel_wdata = sel_wdata | req_wdata[i*DAT +: DAT];
            end
        end
    end

    always_comb begin
        op_onehot           = '0;
        op_onehot[op_idx_q] = 1'b1;
    end

    // Outputs decode from the registered state only, so a reset sampled in
    // ISSUE or DONE still lets that cycle's regfile access or response show.
    always_comb begin
        state_d      = state_q;
        op_idx_d     = op_idx_q;
        op_we_d      = op_we_q;
        op_addr_d    = op_addr_q;
        op_wdata_d   = op_wdata_q;
        last_grant_d = last_grant_q;
        req_ready    = '0;
        rsp_valid    = '0;
        rsp_rdata    = '0;
        rf_CS        = 1'b0;
        rf_WE        = 1'b0;
        rf_RD        = 1'b0;
        rf_Addr      = '0;
        rf_dataIn    = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = arb_grant;
                if (|arb_grant) begin
                    state_d      = ISSUE;
                    op_idx_d     = arb_idx;
                    op_we_d      = sel_we;
                    op_addr_d    = sel_addr;
                    op_wdata_d   = sel_wdata;
                    last_grant_d = arb_idx;
                end
            end
            ISSUE: begin
                rf_CS     = 1'b1;
                rf_WE     = op_we_q;
                rf_RD     = !op_we_q;
                rf_Addr   = op_addr_q;
                rf_dataIn = op_wdata_q;
                state_d   = DONE;
            end
            DONE: begin
                rsp_valid = op_onehot;
                // Writes still pulse rsp_valid as an acknowledge, with zero data.
                rsp_rdata = op_we_q ? '0 : rf_dataOut;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            op_idx_q     <= '0;
            op_we_q      <= 1'b0;
            op_addr_q    <= '0;
            op_wdata_q   <= '0;
            // Starting at the top index makes requester 0 the first winner.
            last_grant_q <= IW'(NREQ - 1);
        end else begin
            state_q      <= state_d;
            op_idx_q     <= op_idx_d;
            op_we_q      <= op_we_d;
            op_addr_q    <= op_addr_d;
            op_wdata_q   <= op_wdata_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - self-checking bench for regfile_arbiter
module tb_regfile_arbiter;

    localparam int ADR  = 8;
    localparam int DAT  = 8;
    localparam int NREQ = 3;

    logic                Clk;
    logic                Rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_we;
    logic [NREQ*ADR-1:0] req_addr;
    logic [NREQ*DAT-1:0] req_wdata;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [DAT-1:0]      rsp_rdata;
    logic                rf_CS;
    logic                rf_WE;
    logic                rf_RD;
    logic [ADR-1:0]      rf_Addr;
    logic [DAT-1:0]      rf_dataIn;
    logic [DAT-1:0]      rf_dataOut;

    regfile_arbiter #(
        .ADR  (ADR),
        .DAT  (DAT),
        .NREQ (NREQ)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rf_CS      (rf_CS),
        .rf_WE      (rf_WE),
        .rf_RD      (rf_RD),
        .rf_Addr    (rf_Addr),
        .rf_dataIn  (rf_dataIn),
        .rf_dataOut (rf_dataOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Regfile environment: synchronous SRAM with registered read data.
    logic           rf_init;
    logic [DAT-1:0] rf_mem [0:(1<<ADR)-1];
    always @(posedge Clk) begin
        if (rf_init) begin
            for (int i = 0; i < (1 << ADR); i++) rf_mem[i] <= '0;
            rf_dataOut <= '0;
        end else begin
            if (rf_CS && rf_WE) rf_mem[rf_Addr] <= rf_dataIn;
            if (rf_CS && rf_RD) rf_dataOut <= rf_mem[rf_Addr];
        end
    end

    // Reference state: requester intents, memory contents, rotation pointer.
    int             tests = 0;
    int             fails = 0;
    logic           chk_en = 1'b0;
    logic           rnd_mode = 1'b0;
    logic           p_valid [NREQ];
    logic           p_keep  [NREQ];
    logic           p_we    [NREQ];
    logic [ADR-1:0] p_addr  [NREQ];
    logic [DAT-1:0] p_wdata [NREQ];
    logic [DAT-1:0] mem_model [0:(1<<ADR)-1];
    int             last;
    int             obs_grant;
    int             acc_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check("we_rd_excl", 32'(rf_WE & rf_RD), 0);
            check("ready_onehot0", 32'($onehot0(req_ready)), 1);
            check("rsp_onehot0", 32'($onehot0(rsp_valid)), 1);
            check("cs_only_issue", 32'(rf_CS && ((|req_ready) || (|rsp_valid) || !(rf_WE ^ rf_RD))), 0);
            check("ctl_without_cs", 32'(!rf_CS && (rf_WE || rf_RD)), 0);
        end
    end

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]              = p_valid[i];
            req_we[i]                 = p_we[i];
            req_addr[i*ADR +: ADR]    = p_addr[i];
            req_wdata[i*DAT +: DAT]   = p_wdata[i];
        end
    endtask

    // Winner: first asking requester after the previous winner, wrapping.
    function automatic int pick();
        int i;
        for (int k = 1; k <= NREQ; k++) begin
            i = (last + k) % NREQ;
            if (p_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic refresh();
        for (int i = 0; i < NREQ; i++) begin
            if (p_valid[i]) begin
                if ($urandom_range(0, 9) == 0) p_valid[i] = 1'b0;
            end else if ($urandom_range(0, 9) < 4) begin
                p_valid[i] = 1'b1;
                p_we[i]    = 1'($urandom_range(0, 1));
                p_addr[i]  = ADR'($urandom_range(0, 15));
                p_wdata[i] = DAT'($urandom);
            end
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [ADR-1:0] a, input logic [DAT-1:0] d);
        p_valid[i] = 1'b1;
        p_we[i]    = we;
        p_addr[i]  = a;
        p_wdata[i] = d;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 0);
        check({tag, "_rsp"}, 32'(rsp_valid), 0);
        check({tag, "_rdata"}, 32'(rsp_rdata), 0);
        check({tag, "_cs"}, 32'(rf_CS), 0);
        check({tag, "_addr"}, 32'(rf_Addr), 0);
        check({tag, "_din"}, 32'(rf_dataIn), 0);
    endtask

    task automatic do_reset(input int ncyc);
        Rst = 1'b1;
        drive();
        repeat (ncyc) begin
            @(negedge Clk);
            check_quiet("rst");
            @(posedge Clk); #1;
        end
        Rst  = 1'b0;
        last = NREQ - 1;
    endtask

    // One IDLE decision; when a grant is expected, follow it through ISSUE
    // and DONE. mid=1: requester 0 raises then withdraws during the op.
    // mid=2: reset asserted in the DONE cycle.
    task automatic slot(input int mid, output int w);
        logic           exp_we;
        logic [ADR-1:0] exp_a;
        logic [DAT-1:0] exp_d;
        logic [DAT-1:0] exp_rd;
        if (rnd_mode) refresh();
        drive();
        @(negedge Clk);
        w = pick();
        obs_grant = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_grant = i;
        if (w < 0) begin
            check("idle_ready", 32'(req_ready), 0);
            check("idle_cs", 32'(rf_CS), 0);
            @(posedge Clk); #1;
            return;
        end
        check("accept", 32'(req_ready), 32'(1 << w));
        acc_cyc = cyc;
        exp_we  = p_we[w];
        exp_a   = p_addr[w];
        exp_d   = p_wdata[w];
        last    = w;
        @(posedge Clk); #1;
        if (!p_keep[w]) p_valid[w] = 1'b0;
        if (rnd_mode) refresh();
        if (mid == 1) set_req(0, 1'b0, 8'h10, 8'h00);
        drive();
        @(negedge Clk);
        check("issue_cs", 32'(rf_CS), 1);
        check("issue_we", 32'(rf_WE), 32'(exp_we));
        check("issue_rd", 32'(rf_RD), 32'(!exp_we));
        check("issue_addr", 32'(rf_Addr), 32'(exp_a));
        check("issue_din", 32'(rf_dataIn), 32'(exp_d));
        check("issue_ready", 32'(req_ready), 0);
        check("issue_rsp", 32'(rsp_valid), 0);
        if (exp_we) begin
            mem_model[exp_a] = exp_d;
            exp_rd = '0;
        end else begin
            exp_rd = mem_model[exp_a];
        end
        @(posedge Clk); #1;
        if (rnd_mode) refresh();
        if (mid == 1) p_valid[0] = 1'b0;
        if (mid == 2) Rst = 1'b1;
        drive();
        @(negedge Clk);
        check("done_rsp", 32'(rsp_valid), 32'(1 << w));
        check("done_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check("done_cs", 32'(rf_CS), 0);
        check("done_ready", 32'(req_ready), 0);
        @(posedge Clk); #1;
        if (mid == 2) begin
            Rst  = 1'b0;
            last = NREQ - 1;
        end
    endtask

    initial begin
        int w;
        int prev;
        Rst     = 1'b1;
        rf_init = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            p_valid[i] = 1'b0; p_keep[i] = 1'b0; p_we[i] = 1'b0;
            p_addr[i]  = '0;   p_wdata[i] = '0;
        end
        for (int i = 0; i < (1 << ADR); i++) mem_model[i] = '0;
        last = NREQ - 1;
        drive();
        @(posedge Clk); #1;
        rf_init = 1'b0;
        do_reset(2);
        chk_en = 1'b1;

        // Reset held while every requester asks: nothing accepted.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, ADR'(i), DAT'(8'h50 + i));
        do_reset(2);
        for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;

        // Write then read back through a different requester.
        set_req(0, 1'b1, 8'd3, 8'hA5);
        slot(0, w);
        check("first_grant", 32'(obs_grant), 0);
        set_req(1, 1'b0, 8'd3, 8'h00);
        slot(0, w);
        check("read_grant", 32'(obs_grant), 1);

        // Two requesters held valid: strict alternation every 3 cycles.
        do_reset(1);
        set_req(0, 1'b1, 8'd20, 8'h11);
        set_req(1, 1'b0, 8'd20, 8'h00);
        p_keep[0] = 1'b1;
        p_keep[1] = 1'b1;
        prev = 0;
        for (int n = 0; n < 6; n++) begin
            slot(0, w);
            check("alt_grant", 32'(obs_grant), 32'(n % 2));
            if (n > 0) check("accept_spacing", 32'(acc_cyc - prev), 3);
            prev = acc_cyc;
        end
        p_keep[0] = 1'b0; p_keep[1] = 1'b0;
        p_valid[0] = 1'b0; p_valid[1] = 1'b0;

        // Requester 0 withdraws while requester 1 is serviced.
        set_req(1, 1'b0, 8'd3, 8'h00);
        slot(1, w);
        for (int n = 0; n < 3; n++) begin
            drive();
            @(negedge Clk);
            check_quiet("withdrawn");
            @(posedge Clk); #1;
        end

        // Reset during ISSUE of a write: access lands, no response.
        set_req(0, 1'b1, 8'd7, 8'h3C);
        drive();
        @(negedge Clk);
        check("rst_issue_accept", 32'(req_ready), 1);
        @(posedge Clk); #1;
        p_valid[0] = 1'b0;
        Rst = 1'b1;
        drive();
        @(negedge Clk);
        check("rst_issue_cs", 32'(rf_CS), 1);
        check("rst_issue_we", 32'(rf_WE), 1);
        check("rst_issue_addr", 32'(rf_Addr), 7);
        check("rst_issue_din", 32'(rf_dataIn), 32'h3C);
        @(posedge Clk); #1;
        Rst  = 1'b0;
        last = NREQ - 1;
        mem_model[7] = 8'h3C;
        @(negedge Clk);
        check_quiet("after_rst_issue");
        check("regfile_got_write", 32'(rf_mem[7]), 32'h3C);
        @(posedge Clk); #1;
        set_req(1, 1'b0, 8'd7, 8'h00);
        slot(0, w);
        check("readback_grant", 32'(obs_grant), 1);

        // Reset in DONE: the response still shows; next winner is requester 0.
        set_req(2, 1'b1, 8'd9, 8'h5A);
        slot(2, w);
        set_req(0, 1'b0, 8'd9, 8'h00);
        set_req(2, 1'b0, 8'd9, 8'h00);
        slot(0, w);
        check("post_rst_done_grant", 32'(obs_grant), 0);
        p_valid[2] = 1'b0;

        // Randomized traffic against the reference model.
        rnd_mode = 1'b1;
        for (int n = 0; n < 80; n++) slot(0, w);
        rnd_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
        drive();
        repeat (3) @(posedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
